// File: rtl/u_wb_pipe.sv
// DEPTH-entry write-back delay line: results reach the RF write port DEPTH cycles after acceptance.
// Outstanding loads are filled by LSU data in flight; the whole line freezes (in_rdy=0) while the oldest entry waits for its data.
module u_wb_pipe #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int NFWD  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic                 in_ld,
    input  logic [AW-1:0]        in_a,
    input  logic [XLEN-1:0]      in_d,
    input  logic                 flush,
    output logic                 in_rdy,
    output logic                 hold,
    input  logic                 ld_vld,
    input  logic [XLEN-1:0]      ld_d,
    input  logic [NFWD*AW-1:0]   fwd_a,
    output logic [NFWD-1:0]      fwd_hit,
    output logic [NFWD-1:0]      fwd_rdy,
    output logic [NFWD*XLEN-1:0] fwd_d,
    output logic                 rf_rd_e,
    output logic [AW-1:0]        rf_rd_a,
    output logic [XLEN-1:0]      rf_rd_i
);
    logic [DEPTH-1:0] ent_v, ent_p, nxt_v, nxt_p;
    logic [AW-1:0]    ent_a [DEPTH];
    logic [AW-1:0]    nxt_a [DEPTH];
    logic [XLEN-1:0]  ent_d [DEPTH];
    logic [XLEN-1:0]  nxt_d [DEPTH];
    logic             accept, new_v, fill_found;
    int               fill_idx, fill_dst;

    assign hold    = ent_v[DEPTH-1] & ent_p[DEPTH-1];
    assign in_rdy  = ~hold;
    assign accept  = in_vld & ~flush & ~hold;
    // x0 destinations never become live entries, loads included
    assign new_v   = accept & (in_a != '0);

    assign rf_rd_e = ent_v[DEPTH-1] & ~ent_p[DEPTH-1];
    assign rf_rd_a = ent_a[DEPTH-1];
    assign rf_rd_i = ent_d[DEPTH-1];

    // Oldest pending entry; its destination slot depends on whether the line shifts
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_v[i] && ent_p[i]) begin
                fill_found = 1'b1;
                fill_idx   = i;
            end
        end
        fill_dst = hold ? fill_idx : fill_idx + 1;
    end

    always_comb begin
        nxt_v = ent_v;
        nxt_p = ent_p;
        nxt_a = ent_a;
        nxt_d = ent_d;
        if (!hold) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                nxt_v[i] = ent_v[i-1];
                nxt_p[i] = ent_p[i-1];
                nxt_a[i] = ent_a[i-1];
                nxt_d[i] = ent_d[i-1];
            end
            nxt_v[0] = new_v;
            nxt_p[0] = new_v & in_ld;
            nxt_a[0] = in_a;
            nxt_d[0] = in_ld ? '0 : in_d;
        end
        if (ld_vld && fill_found) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == fill_dst) begin
                    nxt_d[i] = ld_d;
                    nxt_p[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_v <= '0;
            ent_p <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_a[i] <= '0;
                ent_d[i] <= '0;
            end
        end else begin
            ent_v <= nxt_v;
            ent_p <= nxt_p;
            ent_a <= nxt_a;
            ent_d <= nxt_d;
        end
    end

    // Scan oldest to youngest so the youngest match is the last assignment
    always_comb begin
        fwd_hit = '0;
        fwd_rdy = '0;
        fwd_d   = '0;
        for (int k = 0; k < NFWD; k++) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (ent_v[i] && (fwd_a[k*AW +: AW] != '0) && (ent_a[i] == fwd_a[k*AW +: AW])) begin
                    fwd_hit[k]              = 1'b1;
                    fwd_rdy[k]              = ~ent_p[i];
                    fwd_d[k*XLEN +: XLEN]   = ent_d[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_u_wb_pipe.sv
// Bench for u_wb_pipe: directed scenarios on DEPTH=3/NFWD=2, random streams on both DEPTH=3 and DEPTH=1/NFWD=4.
module tb_u_wb_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int chk = 0;
    int pass = 0;

    // DEPTH=3, NFWD=2 instance
    logic        r3, v3, ld3, fl3, rdy3, hold3, lv3, we3;
    logic [4:0]  a3, wa3;
    logic [31:0] d3, ldd3, wd3;
    logic [9:0]  fa3;
    logic [1:0]  fh3, fr3;
    logic [63:0] fd3;

    // DEPTH=1, NFWD=4 instance
    logic         r1, v1, ld1, fl1, rdy1, hold1, lv1, we1;
    logic [4:0]   a1, wa1;
    logic [31:0]  d1, ldd1, wd1;
    logic [19:0]  fa1;
    logic [3:0]   fh1, fr1;
    logic [127:0] fd1;

    u_wb_pipe #(.XLEN(32), .AW(5), .DEPTH(3), .NFWD(2)) dut3 (
        .clk(clk), .rst(r3), .in_vld(v3), .in_ld(ld3), .in_a(a3), .in_d(d3),
        .flush(fl3), .in_rdy(rdy3), .hold(hold3), .ld_vld(lv3), .ld_d(ldd3),
        .fwd_a(fa3), .fwd_hit(fh3), .fwd_rdy(fr3), .fwd_d(fd3),
        .rf_rd_e(we3), .rf_rd_a(wa3), .rf_rd_i(wd3)
    );

    u_wb_pipe #(.XLEN(32), .AW(5), .DEPTH(1), .NFWD(4)) dut1 (
        .clk(clk), .rst(r1), .in_vld(v1), .in_ld(ld1), .in_a(a1), .in_d(d1),
        .flush(fl1), .in_rdy(rdy1), .hold(hold1), .ld_vld(lv1), .ld_d(ldd1),
        .fwd_a(fa1), .fwd_hit(fh1), .fwd_rdy(fr1), .fwd_d(fd1),
        .rf_rd_e(we1), .rf_rd_a(wa1), .rf_rd_i(wd1)
    );

    typedef struct {
        bit          v;
        bit          p;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    // Reference model: queue of in-flight records, index 0 youngest, back is the RF-bound one
    ent_t q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle3;
        v3 = 0; ld3 = 0; fl3 = 0; lv3 = 0; a3 = '0; d3 = '0; ldd3 = '0; fa3 = '0;
    endtask

    task automatic idle1;
        v1 = 0; ld1 = 0; fl1 = 0; lv1 = 0; a1 = '0; d1 = '0; ldd1 = '0; fa1 = '0;
    endtask

    task automatic test_reset;
        r3 = 1; idle3; tick; tick; r3 = 0;
        chk++; if (we3 !== 1'b0) $display("FAIL reset_we: got %0h exp 0", we3); else pass++;
        chk++; if (wa3 !== 5'd0) $display("FAIL reset_wa: got %0h exp 0", wa3); else pass++;
        chk++; if (wd3 !== 32'd0) $display("FAIL reset_wd: got %0h exp 0", wd3); else pass++;
        chk++; if (hold3 !== 1'b0) $display("FAIL reset_hold: got %0h exp 0", hold3); else pass++;
        chk++; if (rdy3 !== 1'b1) $display("FAIL reset_rdy: got %0h exp 1", rdy3); else pass++;
        chk++; if (fh3 !== 2'b00) $display("FAIL reset_fh: got %0h exp 0", fh3); else pass++;
    endtask

    task automatic test_pipe;
        v3 = 1; a3 = 5; d3 = 32'h11; tick;
        a3 = 6; d3 = 32'h22; tick;
        v3 = 0; tick;
        chk++; if (we3 !== 1'b1) $display("FAIL pipe_we0: got %0h exp 1", we3); else pass++;
        chk++; if (wa3 !== 5'd5) $display("FAIL pipe_wa0: got %0h exp 5", wa3); else pass++;
        chk++; if (wd3 !== 32'h11) $display("FAIL pipe_wd0: got %0h exp 11", wd3); else pass++;
        tick;
        chk++; if (we3 !== 1'b1) $display("FAIL pipe_we1: got %0h exp 1", we3); else pass++;
        chk++; if (wa3 !== 5'd6) $display("FAIL pipe_wa1: got %0h exp 6", wa3); else pass++;
        chk++; if (wd3 !== 32'h22) $display("FAIL pipe_wd1: got %0h exp 22", wd3); else pass++;
        tick;
        chk++; if (we3 !== 1'b0) $display("FAIL pipe_we2: got %0h exp 0", we3); else pass++;
    endtask

    task automatic test_fwd_priority;
        v3 = 1; a3 = 7; d3 = 32'd1; tick;
        d3 = 32'd2; tick;
        v3 = 0; fa3 = {5'd0, 5'd7}; #1;
        chk++; if (fh3[0] !== 1'b1) $display("FAIL fwdp_hit0: got %0h exp 1", fh3[0]); else pass++;
        chk++; if (fr3[0] !== 1'b1) $display("FAIL fwdp_rdy0: got %0h exp 1", fr3[0]); else pass++;
        chk++; if (fd3[31:0] !== 32'd2) $display("FAIL fwdp_d0: got %0h exp 2", fd3[31:0]); else pass++;
        chk++; if (fh3[1] !== 1'b0) $display("FAIL fwdp_hit1: got %0h exp 0", fh3[1]); else pass++;
        chk++; if (fd3[63:32] !== 32'd0) $display("FAIL fwdp_d1: got %0h exp 0", fd3[63:32]); else pass++;
        tick;
        chk++; if (we3 !== 1'b1 || wd3 !== 32'd1) $display("FAIL dup_first: got e=%0h d=%0h exp e=1 d=1", we3, wd3); else pass++;
        tick;
        chk++; if (we3 !== 1'b1 || wd3 !== 32'd2) $display("FAIL dup_second: got e=%0h d=%0h exp e=1 d=2", we3, wd3); else pass++;
        fa3 = '0; tick;
    endtask

    task automatic test_load_hold;
        v3 = 1; ld3 = 1; a3 = 9; tick;
        v3 = 0; ld3 = 0; fa3 = {5'd0, 5'd9}; #1;
        chk++; if (fh3[0] !== 1'b1) $display("FAIL ldh_hit: got %0h exp 1", fh3[0]); else pass++;
        chk++; if (fr3[0] !== 1'b0) $display("FAIL ldh_rdy: got %0h exp 0", fr3[0]); else pass++;
        tick; tick;
        chk++; if (hold3 !== 1'b1) $display("FAIL ldh_hold: got %0h exp 1", hold3); else pass++;
        chk++; if (rdy3 !== 1'b0) $display("FAIL ldh_inrdy: got %0h exp 0", rdy3); else pass++;
        chk++; if (we3 !== 1'b0) $display("FAIL ldh_we: got %0h exp 0", we3); else pass++;
        v3 = 1; a3 = 12; d3 = 32'h77; tick;
        chk++; if (hold3 !== 1'b1) $display("FAIL ldh_hold2: got %0h exp 1", hold3); else pass++;
        lv3 = 1; ldd3 = 32'hABCD; tick;
        lv3 = 0; v3 = 0;
        chk++; if (we3 !== 1'b1) $display("FAIL ldh_fill_we: got %0h exp 1", we3); else pass++;
        chk++; if (wa3 !== 5'd9) $display("FAIL ldh_fill_wa: got %0h exp 9", wa3); else pass++;
        chk++; if (wd3 !== 32'hABCD) $display("FAIL ldh_fill_wd: got %0h exp abcd", wd3); else pass++;
        chk++; if (hold3 !== 1'b0) $display("FAIL ldh_release: got %0h exp 0", hold3); else pass++;
        tick;
        chk++; if (we3 !== 1'b0) $display("FAIL ldh_no_ignored_in: got %0h exp 0", we3); else pass++;
        fa3 = '0; tick; tick;
    endtask

    task automatic test_fill_shift;
        v3 = 1; ld3 = 1; a3 = 3; tick;
        ld3 = 0; a3 = 10; d3 = 32'h99; lv3 = 1; ldd3 = 32'h55; tick;
        v3 = 0; lv3 = 0; fa3 = {5'd10, 5'd3}; #1;
        chk++; if (fh3[0] !== 1'b1 || fr3[0] !== 1'b1) $display("FAIL fs_hit_rdy: got h=%0h r=%0h exp 1 1", fh3[0], fr3[0]); else pass++;
        chk++; if (fd3[31:0] !== 32'h55) $display("FAIL fs_d0: got %0h exp 55", fd3[31:0]); else pass++;
        chk++; if (fr3[1] !== 1'b1 || fd3[63:32] !== 32'h99) $display("FAIL fs_p1: got r=%0h d=%0h exp 1 99", fr3[1], fd3[63:32]); else pass++;
        tick;
        chk++; if (we3 !== 1'b1 || wa3 !== 5'd3 || wd3 !== 32'h55) $display("FAIL fs_wr0: got e=%0h a=%0h d=%0h exp 1 3 55", we3, wa3, wd3); else pass++;
        tick;
        chk++; if (we3 !== 1'b1 || wa3 !== 5'd10 || wd3 !== 32'h99) $display("FAIL fs_wr1: got e=%0h a=%0h d=%0h exp 1 a 99", we3, wa3, wd3); else pass++;
        fa3 = '0; tick;
    endtask

    task automatic test_flush_x0;
        v3 = 1; fl3 = 1; a3 = 4; d3 = 32'd1; tick;
        fl3 = 0; a3 = 0; d3 = 32'd2; tick;
        ld3 = 1; tick;
        v3 = 0; ld3 = 0;
        for (int i = 0; i < 4; i++) begin
            chk++; if (we3 !== 1'b0) $display("FAIL fx_we%0d: got %0h exp 0", i, we3); else pass++;
            chk++; if (hold3 !== 1'b0) $display("FAIL fx_hold%0d: got %0h exp 0", i, hold3); else pass++;
            tick;
        end
    endtask

    task automatic test_reset_pending;
        v3 = 1; ld3 = 1; a3 = 9; tick;
        v3 = 0; ld3 = 0; tick; tick;
        chk++; if (hold3 !== 1'b1) $display("FAIL rp_hold_pre: got %0h exp 1", hold3); else pass++;
        r3 = 1; tick; r3 = 0;
        chk++; if (we3 !== 1'b0 || wa3 !== 5'd0 || wd3 !== 32'd0) $display("FAIL rp_out: got e=%0h a=%0h d=%0h exp 0 0 0", we3, wa3, wd3); else pass++;
        chk++; if (hold3 !== 1'b0 || rdy3 !== 1'b1) $display("FAIL rp_hold: got h=%0h r=%0h exp 0 1", hold3, rdy3); else pass++;
        lv3 = 1; ldd3 = 32'hDEAD; tick; lv3 = 0;
        chk++; if (we3 !== 1'b0 || hold3 !== 1'b0) $display("FAIL rp_late: got e=%0h h=%0h exp 0 0", we3, hold3); else pass++;
        v3 = 1; ld3 = 1; a3 = 8; tick;
        v3 = 0; ld3 = 0; fa3 = {5'd0, 5'd8}; #1;
        chk++; if (fh3[0] !== 1'b1 || fr3[0] !== 1'b0) $display("FAIL rp_new_ld: got h=%0h r=%0h exp 1 0", fh3[0], fr3[0]); else pass++;
        lv3 = 1; ldd3 = 32'h1; tick; lv3 = 0; fa3 = '0;
        tick; tick; tick;
    endtask

    task automatic test_random(input int id, input int ncyc);
        int          depth, nf;
        ent_t        e;
        bit          vld, ld, fl, lv, hold_x, exp_e, pend_any, done, eh, er;
        logic [4:0]  a, ga;
        logic [31:0] d, ldd, gd, ed;
        logic [4:0]  fa [4];
        logic        ge, gh, grdy;
        logic [3:0]  fh, fr;
        logic [127:0] fd;
        depth = (id == 0) ? 3 : 1;
        nf    = (id == 0) ? 2 : 4;
        if (id == 0) begin r3 = 1; idle3; end else begin r1 = 1; idle1; end
        tick;
        if (id == 0) r3 = 0; else r1 = 0;
        q.delete();
        for (int i = 0; i < depth; i++) begin
            e.v = 0; e.p = 0; e.a = '0; e.d = '0;
            q.push_back(e);
        end
        repeat (ncyc) begin
            vld = ($urandom % 4) != 0;
            ld  = ($urandom % 4) == 0;
            fl  = ($urandom % 8) == 0;
            a   = 5'($urandom % 8);
            d   = $urandom;
            pend_any = 0;
            foreach (q[j]) if (q[j].v && q[j].p) pend_any = 1;
            lv  = pend_any ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
            ldd = $urandom;
            for (int k = 0; k < 4; k++) fa[k] = 5'($urandom % 8);
            if (id == 0) begin
                v3 = vld; ld3 = ld; fl3 = fl; a3 = a; d3 = d; lv3 = lv; ldd3 = ldd; fa3 = {fa[1], fa[0]};
            end else begin
                v1 = vld; ld1 = ld; fl1 = fl; a1 = a; d1 = d; lv1 = lv; ldd1 = ldd; fa1 = {fa[3], fa[2], fa[1], fa[0]};
            end
            #1;
            if (id == 0) begin
                ge = we3; ga = wa3; gd = wd3; gh = hold3; grdy = rdy3;
                fh = {2'b00, fh3}; fr = {2'b00, fr3}; fd = {64'd0, fd3};
            end else begin
                ge = we1; ga = wa1; gd = wd1; gh = hold1; grdy = rdy1;
                fh = fh1; fr = fr1; fd = fd1;
            end
            hold_x = q[depth-1].v && q[depth-1].p;
            exp_e  = q[depth-1].v && !q[depth-1].p;
            chk++; if (ge !== exp_e) $display("FAIL rnd%0d_we: got %0h exp %0h", id, ge, exp_e); else pass++;
            if (exp_e) begin
                chk++; if (ga !== q[depth-1].a || gd !== q[depth-1].d)
                    $display("FAIL rnd%0d_wr: got a=%0h d=%0h exp a=%0h d=%0h", id, ga, gd, q[depth-1].a, q[depth-1].d);
                else pass++;
            end
            chk++; if (gh !== hold_x || grdy !== !hold_x) $display("FAIL rnd%0d_hold: got h=%0h r=%0h exp h=%0h", id, gh, grdy, hold_x); else pass++;
            for (int k = 0; k < nf; k++) begin
                eh = 0; er = 0; ed = '0;
                for (int j = 0; j < q.size(); j++) begin
                    if (!eh && q[j].v && fa[k] != 5'd0 && q[j].a == fa[k]) begin
                        eh = 1; er = !q[j].p; ed = q[j].d;
                    end
                end
                chk++; if (fh[k] !== eh || fr[k] !== er || fd[k*32 +: 32] !== ed)
                    $display("FAIL rnd%0d_fwd%0d: got h=%0h r=%0h d=%0h exp h=%0h r=%0h d=%0h", id, k, fh[k], fr[k], fd[k*32 +: 32], eh, er, ed);
                else pass++;
            end
            // Oldest outstanding load takes the data, wherever the record ends up after shifting
            if (lv) begin
                done = 0;
                for (int j = q.size() - 1; j >= 0; j--) begin
                    if (!done && q[j].v && q[j].p) begin
                        q[j].d = ldd; q[j].p = 0; done = 1;
                    end
                end
            end
            if (!hold_x) begin
                void'(q.pop_back());
                e.v = vld && !fl && (a != 5'd0);
                e.p = e.v && ld;
                e.a = a;
                e.d = ld ? 32'd0 : d;
                q.push_front(e);
            end
            tick;
        end
        if (id == 0) idle3; else idle1;
    endtask

    initial begin
        r1 = 1; idle1; r3 = 1; idle3;
        test_reset;
        test_pipe;
        test_fwd_priority;
        test_load_hold;
        test_fill_shift;
        test_flush_x0;
        test_reset_pending;
        test_random(0, 400);
        test_random(1, 400);
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
